alu_arbiter: RTL and testbench

Shares the single combinational ALU between two requesters, e.g. the EX stage (port 0) and the branch/address helper unit (port 1).
Each cycle it grants at most one request using round-robin, drives the ALU operands/control and captures the result into a per-requester response register.
Requests and responses use valid/ready handshakes, with a fixed 1-cycle latency from accept to response.

---
 rtl/alu_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one combinational ALU between two
// valid/ready requesters, 1-cycle latency into per-requester result slots.
// Ports:
//   clk, rst (sync, active-high)
//   req0_valid/ready/ctl/a/b, rsp0_valid/ready/out/z  (requester 0)
//   req1_valid/ready/ctl/a/b, rsp1_valid/ready/out/z  (requester 1)
//   alu_ctl/alu_a/alu_b to the ALU, alu_out/alu_z from the ALU
//   stat_grant0/stat_grant1/stat_conflict only when ALU_ARB_STATS_EN is defined
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CTL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [CTL_W-1:0] req0_ctl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_out,
  output logic             rsp0_z,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [CTL_W-1:0] req1_ctl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_out,
  output logic             rsp1_z,
`ifdef ALU_ARB_STATS_EN
  output logic [15:0]      stat_grant0,
  output logic [15:0]      stat_grant1,
  output logic [15:0]      stat_conflict,
`endif
  output logic [CTL_W-1:0] alu_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_z
);

  logic       last_grant;
  logic [1:0] slot_full;
  logic       elig0;
  logic       elig1;
  logic       grant0;
  logic       grant1;

  // A full slot may still accept when it is drained in the same cycle.
  assign elig0 = !rst && req0_valid && (!slot_full[0] || rsp0_ready);
  assign elig1 = !rst && req1_valid && (!slot_full[1] || rsp1_ready);

  // On conflict, the requester not granted last time wins.
  assign grant0 = elig0 && (!elig1 || last_grant);
  assign grant1 = elig1 && (!elig0 || !last_grant);

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign rsp0_valid = slot_full[0];
  assign rsp1_valid = slot_full[1];

  always_comb begin
    alu_ctl = '0;
    alu_a   = '0;
    alu_b   = '0;
    unique case (1'b1)
      grant0: begin
        alu_ctl = req0_ctl;
        alu_a   = req0_a;
        alu_b   = req0_b;
      end
      grant1: begin
        alu_ctl = req1_ctl;
        alu_a   = req1_a;
        alu_b   = req1_b;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      slot_full  <= 2'b00;
      rsp0_out   <= '0;
      rsp0_z     <= 1'b0;
      rsp1_out   <= '0;
      rsp1_z     <= 1'b0;
    end else begin
      if (grant0) begin
        rsp0_out     <= alu_out;
        rsp0_z       <= alu_z;
        slot_full[0] <= 1'b1;
      end else if (rsp0_ready) begin
        slot_full[0] <= 1'b0;
      end
      if (grant1) begin
        rsp1_out     <= alu_out;
        rsp1_z       <= alu_z;
        slot_full[1] <= 1'b1;
      end else if (rsp1_ready) begin
        slot_full[1] <= 1'b0;
      end
      if (grant0) begin
        last_grant <= 1'b0;
      end else if (grant1) begin
        last_grant <= 1'b1;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else begin
      if (grant0 && stat_grant0 != 16'hFFFF) begin
        stat_grant0 <= stat_grant0 + 16'd1;
      end
      if (grant1 && stat_grant1 != 16'hFFFF) begin
        stat_grant1 <= stat_grant1 + 16'd1;
      end
      if (elig0 && elig1 && stat_conflict != 16'hFFFF) begin
        stat_conflict <= stat_conflict + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter,
// with a behavioural ALU model on the alu_* ports.
module tb_alu_arbiter;

  localparam int W = 32;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready;
  logic [C-1:0] req0_ctl;
  logic [W-1:0] req0_a, req0_b;
  logic         rsp0_valid, rsp0_ready;
  logic [W-1:0] rsp0_out;
  logic         rsp0_z;
  logic         req1_valid, req1_ready;
  logic [C-1:0] req1_ctl;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp1_out;
  logic         rsp1_z;
  logic [C-1:0] alu_ctl;
  logic [W-1:0] alu_a, alu_b;
  logic [W-1:0] alu_out;
  logic         alu_z;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]  stat_grant0, stat_grant1, stat_conflict;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .CTL_W(C)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_ctl(req0_ctl), .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_out(rsp0_out), .rsp0_z(rsp0_z),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_ctl(req1_ctl), .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_out(rsp1_out), .rsp1_z(rsp1_z),
`ifdef ALU_ARB_STATS_EN
    .stat_grant0(stat_grant0), .stat_grant1(stat_grant1),
    .stat_conflict(stat_conflict),
`endif
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_z(alu_z)
  );

  // Behavioural ALU
  always_comb begin
    alu_out = '0;
    case (alu_ctl)
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      4'b0010: alu_out = alu_a + alu_b;
      4'b0110: alu_out = alu_a - alu_b;
      4'b0111: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'b1100: alu_out = ~(alu_a | alu_b);
      4'b1101: alu_out = alu_a ^ alu_b;
      default: alu_out = '0;
    endcase
    alu_z = (alu_out == '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req0_ctl = 4'b0010; req0_a = 32'd5; req0_b = 32'd3;
    req1_valid = 1'b1; req1_ctl = 4'b0110; req1_a = 32'd7; req1_b = 32'd7;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
    end
    checks++;
    if (alu_a !== '0 || alu_ctl !== '0) begin
      errors++;
      $display("FAIL reset_alu: got a=%h ctl=%h want 0", alu_a, alu_ctl);
    end
    tick();
    tick();
    checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b%b want 00", rsp0_valid, rsp1_valid);
    end
    checks++;
    if (rsp0_out !== '0 || rsp0_z !== 1'b0 || rsp1_out !== '0 || rsp1_z !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got %h/%b %h/%b want 0", rsp0_out, rsp0_z, rsp1_out, rsp1_z);
    end
  endtask

  task automatic test_single();
    rst = 1'b0;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_ctl = 4'b0010; req0_a = 32'd5; req0_b = 32'd3;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: got %b%b want 10", req0_ready, req1_ready);
    end
    checks++;
    if (alu_ctl !== 4'b0010 || alu_a !== 32'd5 || alu_b !== 32'd3) begin
      errors++;
      $display("FAIL single_alu: got %h %h %h want 2 5 3", alu_ctl, alu_a, alu_b);
    end
    tick();
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_out !== 32'd8 || rsp0_z !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp: got v=%b out=%0d z=%b want 1 8 0", rsp0_valid, rsp0_out, rsp0_z);
    end
    req0_valid = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || alu_a !== '0 || alu_ctl !== '0) begin
      errors++;
      $display("FAIL idle_alu: got rdy=%b a=%h ctl=%h want 0", req0_ready, alu_a, alu_ctl);
    end
    tick();
    checks++;
    if (rsp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: got %b want 0", rsp0_valid);
    end
  endtask

  task automatic test_alternate();
    do_reset();
    req0_valid = 1'b1; req0_ctl = 4'b0010; req0_a = 32'd5; req0_b = 32'd3;
    req1_valid = 1'b1; req1_ctl = 4'b0110; req1_a = 32'd7; req1_b = 32'd7;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic e0;
      e0 = (k % 2 == 0);
      #1;
      checks++;
      if (req0_ready !== e0 || req1_ready !== !e0) begin
        errors++;
        $display("FAIL alt_grant[%0d]: got %b%b want %b%b", k, req0_ready, req1_ready, e0, !e0);
      end
      tick();
      checks++;
      if (e0) begin
        if (rsp0_valid !== 1'b1 || rsp0_out !== 32'd8) begin
          errors++;
          $display("FAIL alt_rsp0[%0d]: got v=%b out=%0d want 1 8", k, rsp0_valid, rsp0_out);
        end
      end else begin
        if (rsp1_valid !== 1'b1 || rsp1_out !== 32'd0 || rsp1_z !== 1'b1) begin
          errors++;
          $display("FAIL alt_rsp1[%0d]: got v=%b out=%0d z=%b want 1 0 1", k, rsp1_valid, rsp1_out, rsp1_z);
        end
      end
    end
`ifdef ALU_ARB_STATS_EN
    checks++;
    if (stat_conflict !== 16'd4 || stat_grant0 !== 16'd2 || stat_grant1 !== 16'd2) begin
      errors++;
      $display("FAIL alt_stats: got c=%0d g0=%0d g1=%0d want 4 2 2", stat_conflict, stat_grant0, stat_grant1);
    end
`endif
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_blocked();
    do_reset();
    req0_valid = 1'b1; req0_ctl = 4'b0010; req0_a = 32'd5; req0_b = 32'd3;
    rsp0_ready = 1'b0;
    tick();
    req0_a = 32'd10; req0_b = 32'd1;
    req1_valid = 1'b1; req1_ctl = 4'b0001; req1_a = 32'd12; req1_b = 32'd3;
    rsp1_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
        errors++;
        $display("FAIL blk_grant[%0d]: got %b%b want 01", k, req0_ready, req1_ready);
      end
      tick();
      checks++;
      if (rsp0_valid !== 1'b1 || rsp0_out !== 32'd8 || rsp1_out !== 32'd15 || rsp1_valid !== 1'b1) begin
        errors++;
        $display("FAIL blk_rsp[%0d]: got v0=%b o0=%0d v1=%b o1=%0d want 1 8 1 15", k, rsp0_valid, rsp0_out, rsp1_valid, rsp1_out);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    tick();
  endtask

  task automatic test_slt();
    req0_valid = 1'b1; req0_ctl = 4'b0111; req0_a = 32'h80000000; req0_b = 32'd1;
    rsp0_ready = 1'b1;
    tick();
    checks++;
    if (rsp0_out !== 32'd1 || rsp0_z !== 1'b0) begin
      errors++;
      $display("FAIL slt_neg: got %0d z=%b want 1 0", rsp0_out, rsp0_z);
    end
    req0_a = 32'd1; req0_b = 32'h80000000;
    tick();
    checks++;
    if (rsp0_out !== 32'd0 || rsp0_z !== 1'b1) begin
      errors++;
      $display("FAIL slt_pos: got %0d z=%b want 0 1", rsp0_out, rsp0_z);
    end
  endtask

  task automatic test_back_to_back();
    req0_ctl = 4'b0010; req0_a = 32'd20; req0_b = 32'd22;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: got %b want 1", req0_ready);
    end
    tick();
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_out !== 32'd42) begin
      errors++;
      $display("FAIL b2b_add: got v=%b out=%0d want 1 42", rsp0_valid, rsp0_out);
    end
    req0_ctl = 4'b1101; req0_a = 32'hF0; req0_b = 32'hFF;
    tick();
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_out !== 32'h0F) begin
      errors++;
      $display("FAIL b2b_xor: got v=%b out=%h want 1 0f", rsp0_valid, rsp0_out);
    end
    req0_ctl = 4'b1100; req0_a = 32'h0; req0_b = 32'hFFFF0000;
    tick();
    checks++;
    if (rsp0_out !== 32'h0000FFFF || rsp0_z !== 1'b0) begin
      errors++;
      $display("FAIL b2b_nor: got %h z=%b want 0000ffff 0", rsp0_out, rsp0_z);
    end
    req0_ctl = 4'b0011; req0_a = 32'd5; req0_b = 32'd5;
    tick();
    checks++;
    if (rsp0_out !== 32'd0 || rsp0_z !== 1'b1) begin
      errors++;
      $display("FAIL b2b_badctl: got %h z=%b want 0 1", rsp0_out, rsp0_z);
    end
    req0_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_valid = 1'b1; req0_ctl = 4'b0000; req0_a = 32'hF; req0_b = 32'h3;
    req1_valid = 1'b1; req1_ctl = 4'b0001; req1_a = 32'h1; req1_b = 32'h2;
    tick();
    tick();
    checks++;
    if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b1 || rsp0_out !== 32'h3 || rsp1_out !== 32'h3) begin
      errors++;
      $display("FAIL mid_fill: got v=%b%b o0=%h o1=%h want 11 3 3", rsp0_valid, rsp1_valid, rsp0_out, rsp1_out);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got %b%b want 00", rsp0_valid, rsp1_valid);
    end
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_first: got %b%b want 10", req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_blocked();
    test_slt();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
